// File: rtl/debounce_pkg.sv
// Shared FSM state type and parameter limits for the debounce_sync block.
package debounce_pkg;

  localparam int SYNC_STAGES_MIN   = 2;
  localparam int SYNC_STAGES_MAX   = 4;
  localparam int STABLE_CYCLES_MIN = 2;
  localparam int STABLE_CYCLES_MAX = 255;

  typedef enum logic [1:0] {
    S_LO   = 2'b00,
    CHK_HI = 2'b01,
    S_HI   = 2'b10,
    CHK_LO = 2'b11
  } state_e;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level.
// Latency DEPTH edges; no backpressure, samples every clock.
module sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d};
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces x_raw; a level change is accepted after STABLE_CYCLES matching samples.
// Latency SYNC_STAGES+STABLE_CYCLES edges; no backpressure, glitch flags each abandoned qualification.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic x_raw,
  output logic x_clean,
  output logic busy,
  output logic glitch
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("debounce_sync: SYNC_STAGES out of range");
  end
  if (STABLE_CYCLES < STABLE_CYCLES_MIN || STABLE_CYCLES > STABLE_CYCLES_MAX) begin : g_bad_stable
    $error("debounce_sync: STABLE_CYCLES out of range");
  end

  logic          x_sync;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          x_clean_q, x_clean_d;
  logic          glitch_q, glitch_d;

  sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (x_raw),
    .q     (x_sync)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_LO;
      cnt_q     <= '0;
      x_clean_q <= 1'b0;
      glitch_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_clean_q <= x_clean_d;
      glitch_q  <= glitch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_clean_d = x_clean_q;
    glitch_d  = 1'b0;
    cnt_inc   = cnt_q + CW'(1);

    case (state_q)
      S_LO: begin
        x_clean_d = 1'b0;
        cnt_d     = '0;
        if (x_sync) begin
          state_d = CHK_HI;
          cnt_d   = CW'(1);
        end
      end
      CHK_HI: begin
        x_clean_d = 1'b0;
        if (x_sync) begin
          // >= keeps the counter bounded even if it were ever corrupted
          if (cnt_inc >= CW'(STABLE_CYCLES)) begin
            state_d   = S_HI;
            cnt_d     = '0;
            x_clean_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d  = S_LO;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end
      end
      S_HI: begin
        x_clean_d = 1'b1;
        cnt_d     = '0;
        if (!x_sync) begin
          state_d = CHK_LO;
          cnt_d   = CW'(1);
        end
      end
      CHK_LO: begin
        x_clean_d = 1'b1;
        if (!x_sync) begin
          if (cnt_inc >= CW'(STABLE_CYCLES)) begin
            state_d   = S_LO;
            cnt_d     = '0;
            x_clean_d = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d  = S_HI;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end
      end
      default: begin
        state_d   = S_LO;
        cnt_d     = '0;
        x_clean_d = 1'b0;
      end
    endcase
  end

  assign x_clean = x_clean_q;
  assign glitch  = glitch_q;
  assign busy    = (state_q == CHK_HI) || (state_q == CHK_LO);

endmodule

// File: tb/tb_debounce_sync.sv
// Two debounce_sync configurations driven by the same x_raw, checked every cycle against a level/run-length model.
module tb_debounce_sync;

  logic clock = 1'b0;
  logic reset;
  logic x_raw;
  logic xc_a, busy_a, gl_a;
  logic xc_b, busy_b, gl_b;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: index 0 = defaults (2,4); index 1 = SYNC_STAGES 3, STABLE_CYCLES 2
  int m_sync[2] = '{2, 3};
  int m_stab[2] = '{4, 2};
  int m_clean[2];
  int m_run[2];
  int m_glitch[2];
  int m_acc[2];
  bit raw_hist[$];

  int gcount[2]   = '{0, 0};
  int edges[2]    = '{0, 0};
  int prev_xc[2]  = '{0, 0};

  always #5 clock = ~clock;

  debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut_a (
    .clock   (clock),
    .reset   (reset),
    .x_raw   (x_raw),
    .x_clean (xc_a),
    .busy    (busy_a),
    .glitch  (gl_a)
  );

  debounce_sync #(.SYNC_STAGES(3), .STABLE_CYCLES(2)) dut_b (
    .clock   (clock),
    .reset   (reset),
    .x_raw   (x_raw),
    .x_clean (xc_b),
    .busy    (busy_b),
    .glitch  (gl_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_clean[i]  = 0;
      m_run[i]    = 0;
      m_glitch[i] = 0;
    end
    raw_hist.delete();
  endtask

  // A change is accepted after STABLE consecutive synchronized samples differing
  // from the current level; any matching sample in between abandons it.
  task automatic model_edge(input bit raw);
    int s;
    for (int i = 0; i < 2; i++) begin
      s = (raw_hist.size() >= m_sync[i]) ? int'(raw_hist[raw_hist.size() - m_sync[i]]) : 0;
      m_glitch[i] = 0;
      if (s != m_clean[i]) begin
        m_run[i]++;
        if (m_run[i] == m_stab[i]) begin
          m_clean[i] = s;
          m_run[i]   = 0;
          m_acc[i]++;
        end
      end else begin
        if (m_run[i] > 0) m_glitch[i] = 1;
        m_run[i] = 0;
      end
    end
    raw_hist.push_back(raw);
  endtask

  task automatic check_outputs();
    chk("a_x_clean", int'(xc_a),   m_clean[0]);
    chk("a_busy",    int'(busy_a), int'(m_run[0] > 0));
    chk("a_glitch",  int'(gl_a),   m_glitch[0]);
    chk("b_x_clean", int'(xc_b),   m_clean[1]);
    chk("b_busy",    int'(busy_b), int'(m_run[1] > 0));
    chk("b_glitch",  int'(gl_b),   m_glitch[1]);
    if (gl_a) gcount[0]++;
    if (gl_b) gcount[1]++;
    if (int'(xc_a) != prev_xc[0]) edges[0]++;
    if (int'(xc_b) != prev_xc[1]) edges[1]++;
    prev_xc[0] = int'(xc_a);
    prev_xc[1] = int'(xc_b);
  endtask

  // Called just after a falling edge; drives, takes one rising edge, checks at the next falling edge.
  task automatic cycle(input bit raw, input bit rst);
    reset = rst;
    x_raw = raw;
    @(posedge clock);
    if (rst) model_reset();
    else     model_edge(raw);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic hold_measure(input bit raw, input string tag, input int exp_a, input int exp_b);
    int ea = -1;
    int eb = -1;
    for (int k = 1; k <= 16; k++) begin
      cycle(raw, 1'b0);
      if (ea < 0 && xc_a == raw) ea = k;
      if (eb < 0 && xc_b == raw) eb = k;
    end
    chk({tag, "_a"}, ea, exp_a);
    chk({tag, "_b"}, eb, exp_b);
  endtask

  initial begin
    int g0;
    int e0[2];
    int a0[2];
    bit lvl;
    bit r;
    int len;

    m_acc = '{0, 0};
    reset = 1'b1;
    x_raw = 1'b1;
    model_reset();
    #1;
    chk("rst_x_clean", int'(xc_a), 0);
    chk("rst_busy",    int'(busy_a), 0);
    chk("rst_glitch",  int'(gl_a), 0);
    chk("rst_cnt",     int'(dut_a.cnt_q), 0);

    @(negedge clock);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);

    // Release with x_raw already high
    hold_measure(1'b1, "rise_latency", 6, 5);
    chk("rise_no_glitch", gcount[0], 0);
    hold_measure(1'b0, "fall_latency", 6, 5);

    // Short bounce from the low level
    g0 = gcount[0];
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (12) cycle(1'b0, 1'b0);
    chk("bounce_glitch_once", gcount[0] - g0, 1);

    hold_measure(1'b1, "rise2_latency", 6, 5);

    // Alternating input from the high level, then hold low
    g0 = gcount[0];
    for (int k = 0; k < 8; k++) cycle(k[0], 1'b0);
    hold_measure(1'b0, "toggle_fall_latency", 6, 5);
    chk("toggle_glitch_count", gcount[0] - g0, 4);

    // Reset in the middle of a rise qualification
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0);
    chk("mid_chk_cnt", int'(dut_a.cnt_q), 3);
    reset = 1'b1;
    #1;
    chk("async_rst_x_clean_a", int'(xc_a), 0);
    chk("async_rst_busy_a",    int'(busy_a), 0);
    chk("async_rst_glitch_a",  int'(gl_a), 0);
    chk("async_rst_cnt_a",     int'(dut_a.cnt_q), 0);
    chk("async_rst_x_clean_b", int'(xc_b), 0);
    g0 = gcount[0];
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    chk("rst_abort_no_glitch", gcount[0] - g0, 0);
    hold_measure(1'b1, "post_reset_latency", 6, 5);

    // Random bouncing segments
    e0[0] = edges[0];
    e0[1] = edges[1];
    a0[0] = m_acc[0];
    a0[1] = m_acc[1];
    lvl = 1'b1;
    for (int seg = 0; seg < 80; seg++) begin
      lvl = $urandom_range(0, 1) != 0;
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        r = ($urandom_range(0, 5) == 0) ? ~lvl : lvl;
        cycle(r, 1'b0);
      end
    end
    repeat (12) cycle(lvl, 1'b0);
    chk("edges_vs_accepted_a", edges[0] - e0[0], m_acc[0] - a0[0]);
    chk("edges_vs_accepted_b", edges[1] - e0[1], m_acc[1] - a0[1]);
    chk("settled_level_a", int'(xc_a), int'(lvl));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
